// File: rtl/dac_arbiter.sv
// -----------------------------------------------------------------------------
// dac_arbiter
//
// Two-requester arbiter feeding a dual-channel 14-bit DAC. Requesters stream
// bursts of 28-bit samples {chB, chA} over a valid/ready/last handshake. A
// burst is granted round-robin, samples are registered straight onto the DAC
// outputs, and every burst is followed by a fixed number of idle-code cycles.
// A burst ends on last, on a stall timeout, or on en_i dropping (abort).
//
// Parameters:
//   TIMEOUT     consecutive stalled BURST cycles before the burst is dropped
//   GAP_CYCLES  idle-code cycles forced between bursts
//   IDLE_CODE   code driven on both DAC channels outside a burst
//
// Ports:
//   adc_clk              sole clock, rising edge
//   adc_rst_i            asynchronous active-low reset
//   en_i                 enable; low blocks grants and aborts an active burst
//   reqN_valid_i         requester N has a sample
//   reqN_data_i          sample {chB[27:14], chA[13:0]}, 2's complement
//   reqN_last_i          final sample of the burst
//   reqN_ready_o         sample from requester N accepted this cycle
//   dac_dat_a_o/_b_o     registered DAC channel samples
//   grant_o              one-hot burst owner, 00 outside BURST
//   busy_o               high in BURST and GAP
//   timeout_o, abort_o   one-cycle pulses on stall timeout / enable abort
// -----------------------------------------------------------------------------
module dac_arbiter #(
    parameter int unsigned  TIMEOUT    = 256,
    parameter int unsigned  GAP_CYCLES = 2,
    parameter logic [13:0]  IDLE_CODE  = 14'h0000
) (
    input  logic        adc_clk,
    input  logic        adc_rst_i,
    input  logic        en_i,
    input  logic        req0_valid_i,
    input  logic [27:0] req0_data_i,
    input  logic        req0_last_i,
    output logic        req0_ready_o,
    input  logic        req1_valid_i,
    input  logic [27:0] req1_data_i,
    input  logic        req1_last_i,
    output logic        req1_ready_o,
    output logic [13:0] dac_dat_a_o,
    output logic [13:0] dac_dat_b_o,
    output logic [1:0]  grant_o,
    output logic        busy_o,
    output logic        timeout_o,
    output logic        abort_o
);

    localparam logic [15:0] TIMEOUT_L = 16'(TIMEOUT);
    localparam logic [7:0]  GAP_LAST  = 8'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StBurst = 2'b01,
        StGap   = 2'b10
    } state_e;

    state_e      r_state;
    logic [1:0]  r_grant;
    // Index of the requester granted most recently; reset value 1 so that
    // req0 wins the first contested decision.
    logic        r_last_gnt;
    logic [15:0] r_stall_cnt;
    logic [7:0]  r_gap_cnt;
    logic [13:0] r_dac_a;
    logic [13:0] r_dac_b;
    logic        r_timeout;
    logic        r_abort;

    logic        w_in_burst;
    logic        w_sel_valid;
    logic        w_sel_last;
    logic [27:0] w_sel_data;
    logic        w_xfer;
    logic [15:0] w_stall_inc;
    logic        w_stall_hit;
    logic        w_any_valid;
    logic        w_pick;

    assign w_in_burst = (r_state == StBurst);

    // Only the granted requester's handshake signals are looked at; grant is
    // one-hot inside BURST and 00 elsewhere.
    assign w_sel_valid = (r_grant[0] & req0_valid_i) | (r_grant[1] & req1_valid_i);
    assign w_sel_last  = (r_grant[0] & req0_last_i)  | (r_grant[1] & req1_last_i);
    assign w_sel_data  = r_grant[1] ? req1_data_i : req0_data_i;

    assign req0_ready_o = w_in_burst & r_grant[0] & en_i;
    assign req1_ready_o = w_in_burst & r_grant[1] & en_i;

    assign w_xfer = w_in_burst & en_i & w_sel_valid;

    // Saturating increment: the counter must never wrap back to zero.
    assign w_stall_inc = (r_stall_cnt == 16'hFFFF) ? 16'hFFFF : (r_stall_cnt + 16'd1);
    assign w_stall_hit = (w_stall_inc >= TIMEOUT_L);

    // Round-robin pick: on contention favour the requester not granted last.
    assign w_any_valid = req0_valid_i | req1_valid_i;
    always_comb begin
        w_pick = 1'b0;
        if (req0_valid_i && req1_valid_i) begin
            w_pick = ~r_last_gnt;
        end else if (req1_valid_i) begin
            w_pick = 1'b1;
        end
    end

    always_ff @(posedge adc_clk or negedge adc_rst_i) begin
        if (!adc_rst_i) begin
            r_state     <= StIdle;
            r_grant     <= 2'b00;
            r_last_gnt  <= 1'b1;
            r_stall_cnt <= 16'd0;
            r_gap_cnt   <= 8'd0;
            r_dac_a     <= IDLE_CODE;
            r_dac_b     <= IDLE_CODE;
            r_timeout   <= 1'b0;
            r_abort     <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            r_abort   <= 1'b0;

            case (r_state)
                StIdle: begin
                    r_dac_a <= IDLE_CODE;
                    r_dac_b <= IDLE_CODE;
                    if (en_i && w_any_valid) begin
                        r_state     <= StBurst;
                        r_grant     <= w_pick ? 2'b10 : 2'b01;
                        r_last_gnt  <= w_pick;
                        r_stall_cnt <= 16'd0;
                    end
                end

                StBurst: begin
                    if (!en_i) begin
                        // Abort takes priority over a coincident timeout.
                        r_state   <= StGap;
                        r_grant   <= 2'b00;
                        r_gap_cnt <= 8'd0;
                        r_abort   <= 1'b1;
                        r_dac_a   <= IDLE_CODE;
                        r_dac_b   <= IDLE_CODE;
                    end else if (w_xfer) begin
                        r_dac_a     <= w_sel_data[13:0];
                        r_dac_b     <= w_sel_data[27:14];
                        r_stall_cnt <= 16'd0;
                        if (w_sel_last) begin
                            // Last sample stays visible during the first GAP cycle.
                            r_state   <= StGap;
                            r_grant   <= 2'b00;
                            r_gap_cnt <= 8'd0;
                        end
                    end else begin
                        r_stall_cnt <= w_stall_inc;
                        if (w_stall_hit) begin
                            r_state   <= StGap;
                            r_grant   <= 2'b00;
                            r_gap_cnt <= 8'd0;
                            r_timeout <= 1'b1;
                            r_dac_a   <= IDLE_CODE;
                            r_dac_b   <= IDLE_CODE;
                        end
                    end
                end

                StGap: begin
                    r_dac_a <= IDLE_CODE;
                    r_dac_b <= IDLE_CODE;
                    if (r_gap_cnt == GAP_LAST) begin
                        r_state     <= StIdle;
                        r_gap_cnt   <= 8'd0;
                        r_stall_cnt <= 16'd0;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 8'd1;
                    end
                end

                default: begin
                    r_state <= StIdle;
                    r_grant <= 2'b00;
                    r_dac_a <= IDLE_CODE;
                    r_dac_b <= IDLE_CODE;
                end
            endcase
        end
    end

    assign dac_dat_a_o = r_dac_a;
    assign dac_dat_b_o = r_dac_b;
    assign grant_o     = r_grant;
    assign busy_o      = (r_state == StBurst) | (r_state == StGap);
    assign timeout_o   = r_timeout;
    assign abort_o     = r_abort;

endmodule

// File: tb/tb_dac_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dac_arbiter
//
// Directed bench for dac_arbiter with default parameters (TIMEOUT=256,
// GAP_CYCLES=2, IDLE_CODE=0). Inputs change 1 time unit after each rising
// edge and outputs are sampled at that point, after the edge has settled.
// -----------------------------------------------------------------------------
module tb_dac_arbiter;

    logic        adc_clk;
    logic        adc_rst_i;
    logic        en_i;
    logic        req0_valid_i;
    logic [27:0] req0_data_i;
    logic        req0_last_i;
    logic        req0_ready_o;
    logic        req1_valid_i;
    logic [27:0] req1_data_i;
    logic        req1_last_i;
    logic        req1_ready_o;
    logic [13:0] dac_dat_a_o;
    logic [13:0] dac_dat_b_o;
    logic [1:0]  grant_o;
    logic        busy_o;
    logic        timeout_o;
    logic        abort_o;

    int n_cmp = 0;
    int n_err = 0;

    dac_arbiter u_dut (
        .adc_clk      (adc_clk),
        .adc_rst_i    (adc_rst_i),
        .en_i         (en_i),
        .req0_valid_i (req0_valid_i),
        .req0_data_i  (req0_data_i),
        .req0_last_i  (req0_last_i),
        .req0_ready_o (req0_ready_o),
        .req1_valid_i (req1_valid_i),
        .req1_data_i  (req1_data_i),
        .req1_last_i  (req1_last_i),
        .req1_ready_o (req1_ready_o),
        .dac_dat_a_o  (dac_dat_a_o),
        .dac_dat_b_o  (dac_dat_b_o),
        .grant_o      (grant_o),
        .busy_o       (busy_o),
        .timeout_o    (timeout_o),
        .abort_o      (abort_o)
    );

    initial adc_clk = 1'b0;
    always #5 adc_clk = ~adc_clk;

    task automatic tick();
        @(posedge adc_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Checks both DAC channels against hand-chosen {b, a} values.
    task automatic check_dac(input string tag, input logic [13:0] a, input logic [13:0] b);
        check({tag, "_a"}, {18'd0, dac_dat_a_o}, {18'd0, a});
        check({tag, "_b"}, {18'd0, dac_dat_b_o}, {18'd0, b});
    endtask

    logic hold_ok;

    initial begin
        adc_rst_i    = 1'b0;
        en_i         = 1'b1;
        req0_valid_i = 1'b1;
        req0_data_i  = {14'h0011, 14'h0101};
        req0_last_i  = 1'b0;
        req1_valid_i = 1'b1;
        req1_data_i  = {14'h0021, 14'h0201};
        req1_last_i  = 1'b0;

        // Reset state, held for two edges with both requesters valid.
        tick();
        tick();
        check("rst_grant",   32'(grant_o), 32'h0);
        check("rst_busy",    32'(busy_o), 32'h0);
        check("rst_ready0",  32'(req0_ready_o), 32'h0);
        check("rst_ready1",  32'(req1_ready_o), 32'h0);
        check("rst_timeout", 32'(timeout_o), 32'h0);
        check("rst_abort",   32'(abort_o), 32'h0);
        check_dac("rst_dac", 14'h0000, 14'h0000);

        // Both valid at release: req0 wins first, three-sample burst.
        adc_rst_i = 1'b1;
        tick();
        check("rr_grant0",  32'(grant_o), 32'h1);
        check("rr_ready0",  32'(req0_ready_o), 32'h1);
        check("rr_ready1",  32'(req1_ready_o), 32'h0);
        check("rr_busy",    32'(busy_o), 32'h1);
        check_dac("decide_dac", 14'h0000, 14'h0000);
        tick();
        check_dac("r0_s0", 14'h0101, 14'h0011);
        req0_data_i = {14'h0012, 14'h0102};
        tick();
        check_dac("r0_s1", 14'h0102, 14'h0012);
        req0_data_i = {14'h0013, 14'h0103};
        req0_last_i = 1'b1;
        tick();
        check_dac("r0_s2", 14'h0103, 14'h0013);
        check("r0_last_grant", 32'(grant_o), 32'h0);
        check("r0_gap_busy",   32'(busy_o), 32'h1);
        check("r0_gap_ready",  32'(req0_ready_o), 32'h0);
        tick();
        check_dac("gap1_dac", 14'h0000, 14'h0000);
        check("gap1_grant", 32'(grant_o), 32'h0);
        tick();
        check("idle_busy",  32'(busy_o), 32'h0);
        check("idle_grant", 32'(grant_o), 32'h0);
        tick();
        check("rr_grant1",  32'(grant_o), 32'h2);
        check("rr1_ready0", 32'(req0_ready_o), 32'h0);
        check("rr1_ready1", 32'(req1_ready_o), 32'h1);
        // req0 keeps valid/last high: it must not influence req1's burst.
        tick();
        check_dac("r1_s0", 14'h0201, 14'h0021);
        check("r1_s0_grant", 32'(grant_o), 32'h2);
        req1_data_i = {14'h0022, 14'h0202};
        tick();
        check_dac("r1_s1", 14'h0202, 14'h0022);
        req1_data_i = {14'h0023, 14'h0203};
        req1_last_i = 1'b1;
        tick();
        check_dac("r1_s2", 14'h0203, 14'h0023);
        check("r1_end_grant", 32'(grant_o), 32'h0);

        // Stall timeout: one sample then 256 stalled cycles.
        req1_valid_i = 1'b0;
        req1_last_i  = 1'b0;
        req0_valid_i = 1'b1;
        req0_last_i  = 1'b0;
        req0_data_i  = {14'h2000, 14'h1FFF};
        tick();
        tick();
        tick();
        check("to_grant", 32'(grant_o), 32'h1);
        tick();
        check_dac("to_sample", 14'h1FFF, 14'h2000);
        req0_valid_i = 1'b0;
        hold_ok = 1'b1;
        for (int i = 0; i < 255; i++) begin
            tick();
            if (dac_dat_a_o !== 14'h1FFF || dac_dat_b_o !== 14'h2000 ||
                timeout_o !== 1'b0 || grant_o !== 2'b01) begin
                hold_ok = 1'b0;
            end
        end
        check("to_hold_255", 32'(hold_ok), 32'h1);
        tick();
        check("to_pulse",  32'(timeout_o), 32'h1);
        check("to_abort",  32'(abort_o), 32'h0);
        check("to_grant0", 32'(grant_o), 32'h0);
        check("to_busy",   32'(busy_o), 32'h1);
        check_dac("to_dac", 14'h0000, 14'h0000);

        // Abort: en_i dropped while the second sample is offered.
        req0_valid_i = 1'b1;
        req0_data_i  = {14'h0444, 14'h0333};
        tick();
        check("to_pulse_end", 32'(timeout_o), 32'h0);
        tick();
        tick();
        check("ab_grant", 32'(grant_o), 32'h1);
        tick();
        check_dac("ab_s0", 14'h0333, 14'h0444);
        req0_data_i = {14'h0666, 14'h0555};
        en_i = 1'b0;
        #1;
        check("ab_ready_low", 32'(req0_ready_o), 32'h0);
        tick();
        check("ab_pulse",   32'(abort_o), 32'h1);
        check("ab_timeout", 32'(timeout_o), 32'h0);
        check("ab_grant0",  32'(grant_o), 32'h0);
        check_dac("ab_dac", 14'h0000, 14'h0000);

        // Only req1 requests, with single-sample bursts: granted every time.
        en_i         = 1'b1;
        req0_valid_i = 1'b0;
        req1_valid_i = 1'b1;
        req1_last_i  = 1'b1;
        req1_data_i  = {14'h3001, 14'h2AAA};
        tick();
        check("ab_pulse_end", 32'(abort_o), 32'h0);
        tick();
        tick();
        check("solo_grant_a", 32'(grant_o), 32'h2);
        tick();
        check_dac("solo_s_a", 14'h2AAA, 14'h3001);
        req1_data_i = {14'h0F0F, 14'h1555};
        tick();
        tick();
        tick();
        check("solo_grant_b", 32'(grant_o), 32'h2);
        req1_last_i = 1'b0;
        req1_data_i = {14'h0ABC, 14'h3FFF};
        tick();
        check_dac("solo_s_b", 14'h3FFF, 14'h0ABC);
        check("solo_mid_grant", 32'(grant_o), 32'h2);

        // Asynchronous reset mid-burst, well away from any clock edge.
        #2;
        adc_rst_i = 1'b0;
        #1;
        check("arst_grant",  32'(grant_o), 32'h0);
        check("arst_busy",   32'(busy_o), 32'h0);
        check("arst_ready1", 32'(req1_ready_o), 32'h0);
        check_dac("arst_dac", 14'h0000, 14'h0000);
        req1_valid_i = 1'b0;
        #1;
        adc_rst_i = 1'b1;
        tick();
        check("post_rst_grant", 32'(grant_o), 32'h0);
        check("post_rst_busy",  32'(busy_o), 32'h0);
        req1_valid_i = 1'b1;
        tick();
        check("post_rst_regrant", 32'(grant_o), 32'h2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
